// File: rtl/warp_scheduler_pkg.sv
// Shared core-level constants and scheduler types for the SIMT core.
package warp_scheduler_pkg;

    localparam int unsigned WARPS_PER_CORE   = 4;
    localparam int unsigned WARP_ID_WIDTH    = 2;
    localparam int unsigned SCHED_AGE_WIDTH  = 8;
    localparam int unsigned SCHED_MAX_GREEDY = 16;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_HOLD
    } sched_state_t;

endpackage

// File: rtl/warp_oldest_picker.sv
// Combinational oldest-warp selector: the largest age among candidates wins, and ties
// go to the lowest warp id. Warps set in i_exclude are never chosen.
module warp_oldest_picker #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned AGE_WIDTH = 8,
    parameter int unsigned ID_WIDTH  = 2
) (
    input  logic [NUM_WARPS-1:0]           i_elig,
    input  logic [NUM_WARPS-1:0]           i_exclude,
    input  logic [NUM_WARPS*AGE_WIDTH-1:0] i_age,
    output logic                           o_found,
    output logic [ID_WIDTH-1:0]            o_id
);

    logic [AGE_WIDTH-1:0] w_best_age;

    // Linear scan from id 0; strict '>' keeps the lowest id on equal ages
    always_comb begin
        o_found    = 1'b0;
        o_id       = '0;
        w_best_age = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (i_elig[i] && !i_exclude[i]) begin
                if (!o_found || (i_age[i*AGE_WIDTH +: AGE_WIDTH] > w_best_age)) begin
                    o_found    = 1'b1;
                    o_id       = ID_WIDTH'(i);
                    w_best_age = i_age[i*AGE_WIDTH +: AGE_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Greedy-then-oldest issue scheduler for one SIMT core.
// Keeps issuing the last warp while it stays eligible (up to MAX_GREEDY in a row), otherwise
// picks the oldest eligible warp. The pick is held on a valid/ready handshake toward decode,
// and every accepted issue pulses the context store's age-update port.
// Optional: define WARP_SCHED_STATS_EN to add issue/stall/idle statistics counters.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int unsigned NUM_WARPS  = WARPS_PER_CORE,
    parameter int unsigned AGE_WIDTH  = SCHED_AGE_WIDTH,
    parameter int unsigned MAX_GREEDY = SCHED_MAX_GREEDY
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WARPS-1:0]           i_warp_valid,
    input  logic [NUM_WARPS-1:0]           i_warp_ready,
    input  logic [NUM_WARPS-1:0]           i_sb_ok,
    input  logic [NUM_WARPS*AGE_WIDTH-1:0] i_warp_age,
    input  logic                           i_flush,
    output logic                           o_issue_valid,
    output logic [WARP_ID_WIDTH-1:0]       o_issue_warp_id,
    input  logic                           i_issue_ready,
    output logic                           o_sched_issued,
    output logic [WARP_ID_WIDTH-1:0]       o_sched_issued_id
`ifdef WARP_SCHED_STATS_EN
    ,
    output logic [31:0]                    o_stat_issue_cnt,
    output logic [31:0]                    o_stat_stall_cnt,
    output logic [31:0]                    o_stat_idle_cnt
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_GREEDY + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_GREEDY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    sched_state_t              r_state;
    logic                      r_issue_valid;
    logic [WARP_ID_WIDTH-1:0]  r_issue_warp_id;
    logic                      r_fallback;
    logic                      r_sched_issued;
    logic [WARP_ID_WIDTH-1:0]  r_sched_issued_id;
    logic [WARP_ID_WIDTH-1:0]  r_greedy_id;
    logic [CNT_WIDTH-1:0]      r_greedy_cnt;
    logic                      r_greedy_has;

    logic [NUM_WARPS-1:0]      w_elig;
    logic                      w_any_elig;
    logic                      w_handshake;
    logic [WARP_ID_WIDTH-1:0]  w_gid_eff;
    logic [CNT_WIDTH-1:0]      w_gcnt_eff;
    logic                      w_ghas_eff;
    logic                      w_greedy_ok;
    logic                      w_forced;
    logic [NUM_WARPS-1:0]      w_excl;
    logic                      w_old_found;
    logic [WARP_ID_WIDTH-1:0]  w_old_id;
    logic [WARP_ID_WIDTH-1:0]  w_pick_id;
    logic                      w_pick_fallback;

    assign w_elig      = i_warp_valid & i_warp_ready & i_sb_ok;
    assign w_any_elig  = |w_elig;
    assign w_handshake = r_issue_valid & i_issue_ready;

    // Greedy state as it will be after this edge, so a back-to-back pick sees the issue
    // that is being accepted right now
    always_comb begin
        w_gid_eff  = r_greedy_id;
        w_gcnt_eff = r_greedy_cnt;
        w_ghas_eff = r_greedy_has;
        if (w_handshake) begin
            w_ghas_eff = 1'b1;
            w_gid_eff  = r_issue_warp_id;
            if (r_fallback) begin
                w_gcnt_eff = CNT_ONE;
            end else if (r_greedy_has && (r_issue_warp_id == r_greedy_id)) begin
                w_gcnt_eff = (r_greedy_cnt == CNT_MAX) ? CNT_MAX : r_greedy_cnt + CNT_ONE;
            end else begin
                w_gcnt_eff = CNT_ONE;
            end
        end
    end

    assign w_greedy_ok = w_ghas_eff && w_elig[w_gid_eff] && (w_gcnt_eff < CNT_MAX);
    assign w_forced    = w_ghas_eff && (w_gcnt_eff == CNT_MAX);

    // Exclude the greedy warp from the oldest search once its run is exhausted
    always_comb begin
        w_excl = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_excl[i] = w_forced && (w_gid_eff == WARP_ID_WIDTH'(i));
        end
    end

    warp_oldest_picker #(
        .NUM_WARPS (NUM_WARPS),
        .AGE_WIDTH (AGE_WIDTH),
        .ID_WIDTH  (WARP_ID_WIDTH)
    ) u_oldest_picker (
        .i_elig    (w_elig),
        .i_exclude (w_excl),
        .i_age     (i_warp_age),
        .o_found   (w_old_found),
        .o_id      (w_old_id)
    );

    // Final pick: greedy, else oldest, else the forced-out greedy warp if it is alone
    always_comb begin
        w_pick_id       = w_old_id;
        w_pick_fallback = 1'b0;
        if (w_greedy_ok) begin
            w_pick_id = w_gid_eff;
        end else if (!w_old_found && w_forced && w_elig[w_gid_eff]) begin
            w_pick_id       = w_gid_eff;
            w_pick_fallback = 1'b1;
        end
    end

    // Issue FSM with registered handshake outputs and greedy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= SCHED_IDLE;
            r_issue_valid     <= 1'b0;
            r_issue_warp_id   <= '0;
            r_fallback        <= 1'b0;
            r_sched_issued    <= 1'b0;
            r_sched_issued_id <= '0;
            r_greedy_id       <= '0;
            r_greedy_cnt      <= '0;
            r_greedy_has      <= 1'b0;
        end else begin
            // The accepted issue is reported even when a flush lands on the same edge
            r_sched_issued <= w_handshake;
            if (w_handshake) begin
                r_sched_issued_id <= r_issue_warp_id;
            end
            if (i_flush) begin
                r_state       <= SCHED_IDLE;
                r_issue_valid <= 1'b0;
                r_fallback    <= 1'b0;
                r_greedy_cnt  <= '0;
                r_greedy_has  <= 1'b0;
            end else begin
                if (w_handshake) begin
                    r_greedy_id  <= w_gid_eff;
                    r_greedy_cnt <= w_gcnt_eff;
                    r_greedy_has <= 1'b1;
                end
                case (r_state)
                    SCHED_IDLE: begin
                        if (w_any_elig) begin
                            r_state         <= SCHED_HOLD;
                            r_issue_valid   <= 1'b1;
                            r_issue_warp_id <= w_pick_id;
                            r_fallback      <= w_pick_fallback;
                        end
                    end
                    SCHED_HOLD: begin
                        if (w_handshake) begin
                            if (w_any_elig) begin
                                r_issue_warp_id <= w_pick_id;
                                r_fallback      <= w_pick_fallback;
                            end else begin
                                r_state       <= SCHED_IDLE;
                                r_issue_valid <= 1'b0;
                                r_fallback    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state       <= SCHED_IDLE;
                        r_issue_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_issue_valid     = r_issue_valid;
    assign o_issue_warp_id   = r_issue_warp_id;
    assign o_sched_issued    = r_sched_issued;
    assign o_sched_issued_id = r_sched_issued_id;

`ifdef WARP_SCHED_STATS_EN
    logic [31:0] r_stat_issue_cnt;
    logic [31:0] r_stat_stall_cnt;
    logic [31:0] r_stat_idle_cnt;

    // Free-running wrap-around statistics, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issue_cnt <= '0;
            r_stat_stall_cnt <= '0;
            r_stat_idle_cnt  <= '0;
        end else if (i_flush) begin
            r_stat_issue_cnt <= '0;
            r_stat_stall_cnt <= '0;
            r_stat_idle_cnt  <= '0;
        end else begin
            if (w_handshake) begin
                r_stat_issue_cnt <= r_stat_issue_cnt + 32'd1;
            end
            if (r_issue_valid && !i_issue_ready) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 32'd1;
            end
            if ((r_state == SCHED_IDLE) && !w_any_elig) begin
                r_stat_idle_cnt <= r_stat_idle_cnt + 32'd1;
            end
        end
    end

    assign o_stat_issue_cnt = r_stat_issue_cnt;
    assign o_stat_stall_cnt = r_stat_stall_cnt;
    assign o_stat_idle_cnt  = r_stat_idle_cnt;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a vector table for single-cycle behaviour plus
// hand-written sequences for greedy runs, stalls, flush and asynchronous reset.
module tb_warp_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  warp_valid;
    logic [3:0]  warp_ready;
    logic [3:0]  sb_ok;
    logic [31:0] warp_age;
    logic        flush;
    logic        issue_valid;
    logic [1:0]  issue_warp_id;
    logic        issue_ready;
    logic        sched_issued;
    logic [1:0]  sched_issued_id;

    int n_checks = 0;
    int n_errors = 0;

    warp_scheduler u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_warp_valid      (warp_valid),
        .i_warp_ready      (warp_ready),
        .i_sb_ok           (sb_ok),
        .i_warp_age        (warp_age),
        .i_flush           (flush),
        .o_issue_valid     (issue_valid),
        .o_issue_warp_id   (issue_warp_id),
        .i_issue_ready     (issue_ready),
        .o_sched_issued    (sched_issued),
        .o_sched_issued_id (sched_issued_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  elig;
        logic [31:0] age;
        logic        rdy;
        logic        fl;
        logic        e_valid;
        logic [1:0]  e_id;
        logic        e_si;
        logic [1:0]  e_sid;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [3:0] elig, input logic [31:0] age, input logic rdy,
                                input logic fl, input logic e_valid, input logic [1:0] e_id,
                                input logic e_si, input logic [1:0] e_sid);
        vec_t v;
        v.elig = elig; v.age = age; v.rdy = rdy; v.fl = fl;
        v.e_valid = e_valid; v.e_id = e_id; v.e_si = e_si; v.e_sid = e_sid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] elig, input logic [31:0] age, input logic rdy,
                          input logic fl);
        warp_valid  = elig;
        warp_ready  = elig;
        sb_ok       = elig;
        warp_age    = age;
        issue_ready = rdy;
        flush       = fl;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(4'b0000, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
        check("rst_issue_id", {30'b0, issue_warp_id}, 32'd0);
        check("rst_sched_issued", {31'b0, sched_issued}, 32'd0);
        check("rst_sched_id", {30'b0, sched_issued_id}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int got;
    logic [1:0] ids [18];
    logic [1:0] exp_ids [18];
    int pulses;

    initial begin
        // Single-cycle vectors; each row applies inputs, clocks once, then compares
        for (int i = 0; i < 5; i++) vecs[i] = mk(4'b0000, 32'h0, 1'b1, 1'b0, 0, 0, 0, 0);
        vecs[5]  = mk(4'b1110, 32'h09090500, 1'b1, 1'b0, 1, 2, 0, 0);
        vecs[6]  = mk(4'b1110, 32'h09090500, 1'b1, 1'b0, 1, 2, 1, 2);
        vecs[7]  = mk(4'b1110, 32'h09090500, 1'b1, 1'b0, 1, 2, 1, 2);
        vecs[8]  = mk(4'b1110, 32'h09090500, 1'b0, 1'b0, 1, 2, 0, 0);
        vecs[9]  = mk(4'b1010, 32'h09090500, 1'b0, 1'b0, 1, 2, 0, 0);
        vecs[10] = mk(4'b1010, 32'h09090500, 1'b1, 1'b0, 1, 3, 1, 2);
        vecs[11] = mk(4'b1010, 32'h09090500, 1'b0, 1'b1, 0, 0, 0, 0);
        vecs[12] = mk(4'b1001, 32'h07000007, 1'b0, 1'b0, 1, 0, 0, 0);
        vecs[13] = mk(4'b1001, 32'h07000007, 1'b1, 1'b0, 1, 0, 1, 0);
        vecs[14] = mk(4'b1001, 32'h07000007, 1'b1, 1'b1, 0, 0, 1, 0);
        vecs[15] = mk(4'b0000, 32'h0, 1'b1, 1'b0, 0, 0, 0, 0);
        vecs[16] = mk(4'b0010, 32'h0, 1'b0, 1'b0, 1, 1, 0, 0);
        vecs[17] = mk(4'b0000, 32'h0, 1'b1, 1'b0, 0, 0, 1, 1);
        vecs[18] = mk(4'b0000, 32'h0, 1'b1, 1'b0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            set_in(vecs[i].elig, vecs[i].age, vecs[i].rdy, vecs[i].fl);
            step();
            check($sformatf("vec%0d_valid", i), {31'b0, issue_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_id", i), {30'b0, issue_warp_id}, {30'b0, vecs[i].e_id});
            check($sformatf("vec%0d_si", i), {31'b0, sched_issued}, {31'b0, vecs[i].e_si});
            if (vecs[i].e_si)
                check($sformatf("vec%0d_sid", i), {30'b0, sched_issued_id},
                      {30'b0, vecs[i].e_sid});
        end

        // Greedy run of 16 on warp 2, forced switch to warp 0, then back to warp 2
        do_reset();
        for (int i = 0; i < 18; i++) exp_ids[i] = (i == 16) ? 2'd0 : 2'd2;
        set_in(4'b0101, 32'h00090003, 1'b1, 1'b0);
        got = 0;
        for (int c = 0; c < 60 && got < 18; c++) begin
            step();
            if (sched_issued) begin
                ids[got] = sched_issued_id;
                got++;
            end
            if (issue_valid && issue_warp_id == 2'd0) sb_ok[0] = 1'b0;
        end
        check("gto_issue_count", got, 18);
        for (int i = 0; i < got; i++)
            check($sformatf("gto_issue%0d_id", i), {30'b0, ids[i]}, {30'b0, exp_ids[i]});

        // Lone warp past the greedy limit keeps issuing every cycle without a bubble
        do_reset();
        set_in(4'b0100, 32'h00090000, 1'b1, 1'b0);
        step();
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sched_issued && sched_issued_id == 2'd2 && issue_valid) pulses++;
        end
        check("lone_warp_pulses", pulses, 20);

        // Stall: id held for 4 cycles while eligibility drops, then one pulse
        do_reset();
        set_in(4'b0010, 32'h00000500, 1'b0, 1'b0);
        step();
        check("hold_load_valid", {31'b0, issue_valid}, 32'd1);
        sb_ok = 4'b0000;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("hold%0d_valid", c), {31'b0, issue_valid}, 32'd1);
            check($sformatf("hold%0d_id", c), {30'b0, issue_warp_id}, 32'd1);
            if (sched_issued) pulses++;
        end
        issue_ready = 1'b1;
        step();
        if (sched_issued) pulses++;
        check("hold_release_sid", {30'b0, sched_issued_id}, 32'd1);
        check("hold_release_valid", {31'b0, issue_valid}, 32'd0);
        step();
        if (sched_issued) pulses++;
        check("hold_pulse_count", pulses, 1);

        // Asynchronous reset mid-HOLD clears outputs before the next edge
        do_reset();
        set_in(4'b1000, 32'h04000000, 1'b0, 1'b0);
        step();
        check("arst_pre_valid", {31'b0, issue_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, issue_valid}, 32'd0);
        check("arst_id", {30'b0, issue_warp_id}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_release_valid", {31'b0, issue_valid}, 32'd0);
        step();
        check("arst_relaunch_valid", {31'b0, issue_valid}, 32'd1);
        check("arst_relaunch_id", {30'b0, issue_warp_id}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
